// File: rtl/camera_capture.sv
// Camera capture front end: synchronizes camera pins into CLOCK_50 and writes each luma byte to a linear framebuffer address.
// Latency: 3 CLOCK_50 cycles from pin pclk/vsync sampled high to registered y/y_valid/wr_addr or frame pulse.
// Backpressure: none; y_valid strobes are at least 2 pclk periods apart, so the consumer must always accept.
module camera_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int Y_FIRST  = 1,
  parameter int ADDR_W   = 19
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              pclk,
  input  logic              href,
  input  logic              vsync,
  input  logic [7:0]        d,
  output logic [7:0]        y,
  output logic              y_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int LP_W = $clog2(H_ACTIVE + 2);
  localparam int LC_W = $clog2(V_ACTIVE + 1);

  localparam logic [ADDR_W:0]   C_TOTAL = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
  localparam logic [ADDR_W:0]   C_PIX1  = (ADDR_W+1)'(1);
  localparam logic [LP_W-1:0]   C_H     = LP_W'(H_ACTIVE);
  localparam logic [LP_W-1:0]   C_HSAT  = LP_W'(H_ACTIVE + 1);
  localparam logic [LP_W-1:0]   C_LP1   = LP_W'(1);
  localparam logic [LC_W-1:0]   C_V     = LC_W'(V_ACTIVE);
  localparam logic [LC_W-1:0]   C_LC1   = LC_W'(1);
  // Byte phase value at which the luma byte is on the bus
  localparam logic              C_YPH   = (Y_FIRST != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_FRAME} state_t;

  logic [2:0]        r_pclk_q;
  logic [2:0]        r_href_q;
  logic [2:0]        r_vs_q;
  logic [7:0]        r_d_s1;
  logic [7:0]        r_d_s2;

  state_t            r_state;
  logic [ADDR_W:0]   r_pix_cnt;
  logic [LP_W-1:0]   r_line_pix;
  logic [LC_W-1:0]   r_line_cnt;
  logic              r_byte_ph;
  logic              r_err;
  logic [7:0]        r_y;
  logic              r_y_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_frame_done;
  logic              r_frame_err;
  logic              r_busy;

  logic w_pclk_rise;
  logic w_vs_rise;
  logic w_vs_fall;
  logic w_href;
  logic w_href_fall;
  logic w_y_byte;

  // Two-stage synchronizers for every pin (d kept aligned with pclk), plus a third stage for edge detection
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_pclk_q <= '0;
      r_href_q <= '0;
      r_vs_q   <= '0;
      r_d_s1   <= '0;
      r_d_s2   <= '0;
    end else begin
      r_pclk_q <= {r_pclk_q[1:0], pclk};
      r_href_q <= {r_href_q[1:0], href};
      r_vs_q   <= {r_vs_q[1:0], vsync};
      r_d_s1   <= d;
      r_d_s2   <= r_d_s1;
    end
  end

  assign w_pclk_rise = r_pclk_q[1] & ~r_pclk_q[2];
  assign w_vs_rise   = r_vs_q[1] & ~r_vs_q[2];
  assign w_vs_fall   = ~r_vs_q[1] & r_vs_q[2];
  assign w_href      = r_href_q[1];
  assign w_href_fall = ~r_href_q[1] & r_href_q[2];
  assign w_y_byte    = w_pclk_rise & w_href & (r_byte_ph == C_YPH);

  // Frame FSM with pixel/line accounting and registered write and status outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pix_cnt    <= '0;
      r_line_pix   <= '0;
      r_line_cnt   <= '0;
      r_byte_ph    <= 1'b0;
      r_err        <= 1'b0;
      r_y          <= '0;
      r_y_valid    <= 1'b0;
      r_wr_addr    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_y_valid    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_vs_rise) r_state <= S_VSYNC;
        end
        S_VSYNC: begin
          r_pix_cnt  <= '0;
          r_line_pix <= '0;
          r_line_cnt <= '0;
          r_byte_ph  <= 1'b0;
          r_err      <= 1'b0;
          if (w_vs_fall) begin
            r_state <= S_FRAME;
            r_busy  <= 1'b1;
          end
        end
        S_FRAME: begin
          if (w_vs_rise) begin
            // vsync takes priority over any coincident pixel byte
            r_state <= S_VSYNC;
            r_busy  <= 1'b0;
            if (r_pix_cnt == C_TOTAL && r_line_cnt == C_V && !r_err) r_frame_done <= 1'b1;
            else                                                      r_frame_err  <= 1'b1;
          end else begin
            if (!w_href)          r_byte_ph <= 1'b0;
            else if (w_pclk_rise) r_byte_ph <= ~r_byte_ph;

            if (w_y_byte) begin
              if (r_pix_cnt != C_TOTAL) begin
                r_y       <= r_d_s2;
                r_wr_addr <= r_pix_cnt[ADDR_W-1:0];
                r_y_valid <= 1'b1;
                r_pix_cnt <= r_pix_cnt + C_PIX1;
                if (r_line_pix != C_HSAT) r_line_pix <= r_line_pix + C_LP1;
              end else begin
                // Frame already full: drop the byte and mark the frame bad
                r_err <= 1'b1;
              end
            end

            if (w_href_fall) begin
              if (r_line_pix != C_H) r_err <= 1'b1;
              r_line_pix <= '0;
              if (r_line_cnt != C_V) r_line_cnt <= r_line_cnt + C_LC1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign y          = r_y;
  assign y_valid    = r_y_valid;
  assign wr_addr    = r_wr_addr;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture with a reduced 4x3 frame: directed camera waveforms feed a scoreboard.
// Two instances share the pins: Y_FIRST=1 (checked throughout) and Y_FIRST=0 (checked in the phase test).
// Expected writes and frame events are queued at stimulus time and popped by a negedge monitor.
module tb_camera_capture;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int TOT = H * V;
  localparam int AW  = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          pclk  = 1'b0;
  logic          href  = 1'b0;
  logic          vsync = 1'b0;
  logic [7:0]    d     = 8'h00;

  logic [7:0]    y0, y1;
  logic          yv0, yv1;
  logic [AW-1:0] a0, a1;
  logic          fd0, fd1, fe0, fe1, b0, b1;

  camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_FIRST(1), .ADDR_W(AW)) dut0 (
    .CLOCK_50(clk), .reset(reset), .pclk(pclk), .href(href), .vsync(vsync), .d(d),
    .y(y0), .y_valid(yv0), .wr_addr(a0), .frame_done(fd0), .frame_err(fe0), .busy(b0)
  );

  camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_FIRST(0), .ADDR_W(AW)) dut1 (
    .CLOCK_50(clk), .reset(reset), .pclk(pclk), .href(href), .vsync(vsync), .d(d),
    .y(y1), .y_valid(yv1), .wr_addr(a1), .frame_done(fd1), .frame_err(fe1), .busy(b1)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { int yv; int addr; int edge_n; } wr_t;
  typedef struct { int kind; int edge_n; } ev_t;   // kind: 2 = frame_done, 1 = frame_err

  wr_t q0[$];
  wr_t q1[$];
  ev_t e0[$];
  ev_t e1[$];
  bit  en1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a write or a frame pulse
  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    if (yv0) begin
      if (q0.size() == 0) unexpected("wr0");
      else begin
        w = q0.pop_front();
        chk("wr0_y", 32'(y0), w.yv);
        chk("wr0_addr", 32'(a0), w.addr);
        if (w.edge_n >= 0) chk("wr0_latency", cyc, w.edge_n);
      end
    end
    if (en1 && yv1) begin
      if (q1.size() == 0) unexpected("wr1");
      else begin
        w = q1.pop_front();
        chk("wr1_y", 32'(y1), w.yv);
        chk("wr1_addr", 32'(a1), w.addr);
        if (w.edge_n >= 0) chk("wr1_latency", cyc, w.edge_n);
      end
    end
    if (fd0 || fe0) begin
      if (e0.size() == 0) unexpected("ev0");
      else begin
        e = e0.pop_front();
        chk("ev0_kind", {30'd0, fd0, fe0}, e.kind);
        chk("ev0_latency", cyc, e.edge_n);
      end
    end
    if (en1 && (fd1 || fe1)) begin
      if (e1.size() == 0) unexpected("ev1");
      else begin
        e = e1.pop_front();
        chk("ev1_kind", {30'd0, fd1, fe1}, e.kind);
        chk("ev1_latency", cyc, e.edge_n);
      end
    end
  end

  // One bus byte: pclk low 2 cycles (d changes on the fall), high 2 cycles
  task automatic pbyte(input logic [7:0] b, input bit p0, input int ad0,
                       input bit p1, input int ad1, input bit lat);
    wr_t w;
    @(negedge clk);
    pclk = 1'b0;
    d    = b;
    repeat (2) @(negedge clk);
    pclk = 1'b1;
    w.yv     = int'(b);
    w.edge_n = lat ? cyc + 3 : -1;
    if (p0) begin w.addr = ad0; q0.push_back(w); end
    if (p1) begin w.addr = ad1; q1.push_back(w); end
    @(negedge clk);
  endtask

  task automatic href_on();
    @(negedge clk);
    href = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic href_off();
    repeat (2) @(negedge clk);
    href = 1'b0;
    pclk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // A line whose Y bytes carry the low 8 bits of the pixel index
  task automatic send_line(input int nbytes, input int start, input bit wr);
    href_on();
    for (int i = 0; i < nbytes; i++) begin
      int pix;
      logic [7:0] b;
      pix = start + i / 2;
      b   = (i % 2 == 0) ? pix[7:0] : 8'hE5;
      pbyte(b, wr && (i % 2 == 0) && (pix < TOT), pix, 1'b0, 0, 1'b0);
    end
    href_off();
  endtask

  task automatic vs_pulse(input int k0, input int k1);
    ev_t e;
    @(negedge clk);
    vsync    = 1'b1;
    e.edge_n = cyc + 3;
    if (k0 != 0) begin e.kind = k0; e0.push_back(e); end
    if (k1 != 0) begin e.kind = k1; e1.push_back(e); end
    repeat (6) @(negedge clk);
    vsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_y"}, 32'(y0), 0);
    chk({tag, "_y_valid"}, 32'(yv0), 0);
    chk({tag, "_wr_addr"}, 32'(a0), 0);
    chk({tag, "_frame_done"}, 32'(fd0), 0);
    chk({tag, "_frame_err"}, 32'(fe0), 0);
    chk({tag, "_busy"}, 32'(b0), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(b0), 0);

    // Latency and byte phase on both Y_FIRST settings
    en1 = 1'b1;
    vs_pulse(0, 0);
    chk("frame_busy0", 32'(b0), 1);
    chk("frame_busy1", 32'(b1), 1);
    href_on();
    pbyte(8'h11, 1'b1, 0, 1'b0, 0, 1'b1);
    pbyte(8'h22, 1'b0, 0, 1'b1, 0, 1'b1);
    pbyte(8'h33, 1'b1, 1, 1'b0, 0, 1'b1);
    pbyte(8'h44, 1'b0, 0, 1'b1, 1, 1'b1);
    href_off();
    vs_pulse(1, 1);
    en1 = 1'b0;

    // Nominal frame
    for (int l = 0; l < V; l++) send_line(2 * H, l * H, 1'b1);
    vs_pulse(2, 0);

    // Short middle line: addresses stay contiguous, frame is flagged bad
    send_line(2 * H, 0, 1'b1);
    send_line(2 * H - 2, H, 1'b1);
    send_line(2 * H, 2 * H - 1, 1'b1);
    vs_pulse(1, 0);

    // One line too many: writes stop at TOT-1
    for (int l = 0; l <= V; l++) send_line(2 * H, l * H, 1'b1);
    vs_pulse(1, 0);

    // Asynchronous reset in the middle of a line
    href_on();
    for (int i = 0; i < 4; i++)
      pbyte((i % 2 == 0) ? 8'(i / 2) : 8'hE5, (i % 2 == 0), i / 2, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_reset_y", 32'(y0), 1);
    chk("pre_reset_addr", 32'(a0), 1);
    chk("pre_reset_busy", 32'(b0), 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_zero("async_reset");
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 4; i < 2 * H; i++) pbyte(8'hE5, 1'b0, 0, 1'b0, 0, 1'b0);
    href_off();

    // Reset released mid-frame: nothing until a full vsync pulse, then a clean frame
    @(negedge clk);
    reset = 1'b1;
    vs_pulse(0, 0);
    send_line(2 * H, 0, 1'b0);
    href_on();
    for (int i = 0; i < 4; i++) pbyte(8'h5A, 1'b0, 0, 1'b0, 0, 1'b0);
    reset = 1'b0;
    for (int i = 4; i < 2 * H; i++) pbyte(8'h5A, 1'b0, 0, 1'b0, 0, 1'b0);
    href_off();
    send_line(2 * H, 2 * H, 1'b0);
    chk("midframe_busy", 32'(b0), 0);
    vs_pulse(0, 0);
    for (int l = 0; l < V; l++) send_line(2 * H, l * H, 1'b1);
    vs_pulse(2, 0);

    repeat (10) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("e0_drained", e0.size(), 0);
    chk("e1_drained", e1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
